srl_share_ctrl: RTL

- Shares one fixed-length srl delay line between NUM_REQ requesters using round-robin arbitration. Each requester has a valid/ready input channel.
- Runs a valid/tag shadow pipeline in lockstep with the srl. Each delayed word leaves on one output channel, tagged with its requester index.
- Stalls the shared srl through its enable when the consumer applies backpressure.
- Sits between per-channel producers and the srl instance. The srl instance stays a plain external sub-block.

---
 rtl/srl_ctrl_pkg.sv | 20 ++
 rtl/srl_share_ctrl_if.sv | 26 ++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/srl_share_ctrl.sv | 92 +++++++++
 4 files changed

// File: rtl/srl_ctrl_pkg.sv
// Shared constants and helpers for the shared-srl controller and its arbiter.
package srl_ctrl_pkg;

    localparam int SRL_DEF_WIDTH  = 18;
    localparam int SRL_DEF_LENGTH = 32;

    // Ceiling log2 for elaboration-time sizing; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/srl_share_ctrl_if.sv
// Requester and output channels of srl_share_ctrl.
// Handshake: a word moves on a channel at a clk edge where its valid and ready are both high;
// valid must never depend combinationally on ready, and ready here is combinational from valid.
interface srl_share_ctrl_if #(
    parameter int DATA_WIDTH = srl_ctrl_pkg::SRL_DEF_WIDTH,
    parameter int NUM_REQ    = 4,
    parameter int TAG_W      = srl_ctrl_pkg::clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          out_valid;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [TAG_W-1:0]              out_tag;
    logic                          out_ready;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester above the last grant, wrapping.
// The pointer moves only when a grant is actually issued.
module rr_arbiter
    import srl_ctrl_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int TAG_W   = clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [TAG_W-1:0]   index
);

    logic [TAG_W-1:0] last_grant;
    logic [TAG_W-1:0] cand;
    logic             found;

    always_comb begin
        grant = '0;
        index = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = TAG_W'((int'(last_grant) + i) % NUM_REQ);
            if (enable && !found && req[cand]) begin
                grant[cand] = 1'b1;
                index       = cand;
                found       = 1'b1;
            end
        end
    end

    // Reset pointer to the top index so requester 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= TAG_W'(NUM_REQ - 1);
        end else if (found) begin
            last_grant <= index;
        end
    end

endmodule

// File: rtl/srl_share_ctrl.sv
// Shares one external srl delay line among NUM_REQ requesters, tracking valid/tag in a
// shadow pipeline that shifts in lockstep with the srl enable.
module srl_share_ctrl
    import srl_ctrl_pkg::*;
#(
    parameter  int DATA_WIDTH = SRL_DEF_WIDTH,
    parameter  int SRL_LENGTH = SRL_DEF_LENGTH,
    parameter  int NUM_REQ    = 4,
    localparam int TAG_W      = clog2(NUM_REQ),
    localparam int OCC_W      = clog2(SRL_LENGTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    srl_share_ctrl_if.slave       bus,
    output logic                  srl_en,
    output logic [DATA_WIDTH-1:0] srl_din,
    input  logic [DATA_WIDTH-1:0] srl_dout,
    output logic [OCC_W-1:0]      occupancy,
    output logic                  busy
);

    logic                  adv;
    logic                  arb_en;
    logic                  accept;
    logic                  fire;
    logic [NUM_REQ-1:0]    grant;
    logic [TAG_W-1:0]      grant_idx;
    logic [SRL_LENGTH-1:0] shadow_valid;
    logic [TAG_W-1:0]      shadow_tag [SRL_LENGTH];

    // The whole line moves only when the head is empty or being consumed.
    assign adv    = !shadow_valid[SRL_LENGTH-1] || bus.out_ready;
    assign arb_en = adv && !flush && !rst;
    assign accept = |grant;
    assign fire   = shadow_valid[SRL_LENGTH-1] && bus.out_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.req_valid),
        .enable (arb_en),
        .grant  (grant),
        .index  (grant_idx)
    );

    assign bus.req_ready = grant;
    assign srl_en        = adv;

    always_comb begin
        srl_din = '0;
        if (accept) begin
            srl_din = bus.req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Valid bits carry reset/flush; stale srl contents are hidden behind them.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            shadow_valid <= '0;
        end else if (adv) begin
            shadow_valid <= {shadow_valid[SRL_LENGTH-2:0], accept};
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            shadow_tag[0] <= accept ? grant_idx : '0;
            for (int i = 1; i < SRL_LENGTH; i++) begin
                shadow_tag[i] <= shadow_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occupancy <= '0;
        end else if (accept && !fire) begin
            occupancy <= occupancy + 1'b1;
        end else if (fire && !accept) begin
            occupancy <= occupancy - 1'b1;
        end
    end

    assign busy          = (occupancy != '0);
    assign bus.out_valid = shadow_valid[SRL_LENGTH-1];
    assign bus.out_tag   = shadow_tag[SRL_LENGTH-1];
    assign bus.out_data  = srl_dout;

endmodule
